// File: rtl/sram_stage_sequencer_if.sv
// Bundle of the sequencer's handshake, requester and SRAM port signals.
// The master modport is the sequencer's own view. The slave modport is the
// view of the environment around it: the UART loader, the milestones, VGA
// and the physical SRAM.
interface sram_stage_sequencer_if;
    logic        start;
    logic        skip_m2;

    logic        uart_enable;
    logic        uart_done;
    logic [17:0] uart_addr;
    logic [15:0] uart_wdata;
    logic        uart_we_n;

    logic        m2_start;
    logic        m2_done;
    logic [17:0] m2_addr;
    logic [15:0] m2_wdata;
    logic        m2_we_n;

    logic        m1_start;
    logic        m1_done;
    logic [17:0] m1_addr;
    logic [15:0] m1_wdata;
    logic        m1_we_n;

    logic        vga_enable;
    logic [17:0] vga_addr;

    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    logic        busy;
    logic        error;
    logic [2:0]  state_code;
    logic [31:0] m2_cycles;
    logic [31:0] m1_cycles;

    modport master (
        input  start, skip_m2,
        input  uart_done, uart_addr, uart_wdata, uart_we_n,
        input  m2_done, m2_addr, m2_wdata, m2_we_n,
        input  m1_done, m1_addr, m1_wdata, m1_we_n,
        input  vga_addr,
        output uart_enable, m2_start, m1_start, vga_enable,
        output SRAM_address, SRAM_write_data, SRAM_we_n,
        output busy, error, state_code, m2_cycles, m1_cycles
    );

    modport slave (
        output start, skip_m2,
        output uart_done, uart_addr, uart_wdata, uart_we_n,
        output m2_done, m2_addr, m2_wdata, m2_we_n,
        output m1_done, m1_addr, m1_wdata, m1_we_n,
        output vga_addr,
        input  uart_enable, m2_start, m1_start, vga_enable,
        input  SRAM_address, SRAM_write_data, SRAM_we_n,
        input  busy, error, state_code, m2_cycles, m1_cycles
    );
endinterface

// File: rtl/sram_stage_sequencer.sv
// Top-level sequencer for the image decoder's single SRAM port.
// It steps through UART load, M2 (IDCT), M1 (YUV->RGB) and VGA display.
// Whichever stage is active owns the SRAM lines, and the port selection
// comes directly from the state register. M2 and M1 each have a watchdog.
// The sequencer also reports how many cycles each milestone took.
module sram_stage_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
    input  logic                  clock_i,
    input  logic                  resetn_i,
    sram_stage_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_UART    = 3'd1,
        S_M2      = 3'd2,
        S_M1      = 3'd3,
        S_DISPLAY = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    localparam logic [31:0] TerminalCount = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        skipM2_q, skipM2_d;
    logic        error_q, error_d;
    logic [31:0] watchdog_q, watchdog_d;
    logic [31:0] m2Cycles_q, m2Cycles_d;
    logic [31:0] m1Cycles_q, m1Cycles_d;
    logic        m2Start_q, m2Start_d;
    logic        m1Start_q, m1Start_d;

    // State, status and start-pulse registers with synchronous active-low reset.
    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            state_q    <= S_IDLE;
            skipM2_q   <= 1'b0;
            error_q    <= 1'b0;
            watchdog_q <= '0;
            m2Cycles_q <= '0;
            m1Cycles_q <= '0;
            m2Start_q  <= 1'b0;
            m1Start_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            skipM2_q   <= skipM2_d;
            error_q    <= error_d;
            watchdog_q <= watchdog_d;
            m2Cycles_q <= m2Cycles_d;
            m1Cycles_q <= m1Cycles_d;
            m2Start_q  <= m2Start_d;
            m1Start_q  <= m1Start_d;
        end
    end

    // Next-state logic. A done pulse takes priority over the watchdog terminal count.
    always_comb begin
        state_d    = state_q;
        skipM2_d   = skipM2_q;
        error_d    = error_q;
        watchdog_d = '0;
        m2Cycles_d = m2Cycles_q;
        m1Cycles_d = m1Cycles_q;

        case (state_q)
            S_IDLE, S_DISPLAY, S_ERROR: begin
                if (bus.start) begin
                    state_d    = S_UART;
                    skipM2_d   = bus.skip_m2;
                    error_d    = 1'b0;
                    m2Cycles_d = '0;
                    m1Cycles_d = '0;
                end
            end
            S_UART: begin
                if (bus.uart_done) begin
                    state_d = skipM2_q ? S_M1 : S_M2;
                end
            end
            S_M2: begin
                m2Cycles_d = m2Cycles_q + 32'd1;
                watchdog_d = watchdog_q + 32'd1;
                if (bus.m2_done) begin
                    state_d = S_M1;
                end else if (watchdog_q == TerminalCount) begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                end
            end
            S_M1: begin
                m1Cycles_d = m1Cycles_q + 32'd1;
                watchdog_d = watchdog_q + 32'd1;
                if (bus.m1_done) begin
                    state_d = S_DISPLAY;
                end else if (watchdog_q == TerminalCount) begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Each milestone run starts with a fresh watchdog.
        if (state_d != state_q) begin
            watchdog_d = '0;
        end

        m2Start_d = (state_d == S_M2) && (state_q != S_M2);
        m1Start_d = (state_d == S_M1) && (state_q != S_M1);
    end

    // SRAM port mux. Only the current owner can reach the write-enable line.
    always_comb begin
        bus.SRAM_address    = '0;
        bus.SRAM_write_data = '0;
        bus.SRAM_we_n       = 1'b1;
        case (state_q)
            S_UART: begin
                bus.SRAM_address    = bus.uart_addr;
                bus.SRAM_write_data = bus.uart_wdata;
                bus.SRAM_we_n       = bus.uart_we_n;
            end
            S_M2: begin
                bus.SRAM_address    = bus.m2_addr;
                bus.SRAM_write_data = bus.m2_wdata;
                bus.SRAM_we_n       = bus.m2_we_n;
            end
            S_M1: begin
                bus.SRAM_address    = bus.m1_addr;
                bus.SRAM_write_data = bus.m1_wdata;
                bus.SRAM_we_n       = bus.m1_we_n;
            end
            S_DISPLAY: begin
                bus.SRAM_address    = bus.vga_addr;
            end
            default: begin
                bus.SRAM_address    = '0;
            end
        endcase
    end

    assign bus.uart_enable = (state_q == S_UART);
    assign bus.vga_enable  = (state_q == S_DISPLAY);
    assign bus.busy        = (state_q == S_UART) || (state_q == S_M2) || (state_q == S_M1);
    assign bus.m2_start    = m2Start_q;
    assign bus.m1_start    = m1Start_q;
    assign bus.error       = error_q;
    assign bus.state_code  = state_q;
    assign bus.m2_cycles   = m2Cycles_q;
    assign bus.m1_cycles   = m1Cycles_q;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Directed testbench for sram_stage_sequencer. The watchdog is shortened
// to 16 cycles so the timeout paths can be reached quickly.
module tb_sram_stage_sequencer;

    logic clock;
    logic resetn;
    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;

    sram_stage_sequencer_if bus ();

    sram_stage_sequencer #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock_i  (clock),
        .resetn_i (resetn),
        .bus      (bus.master)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance by the given number of rising edges and land 1 unit past the last one.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // The directed sequence. Inputs change 1 unit after an edge and are checked before the next edge.
    initial begin
        resetn          = 1'b0;
        bus.start       = 1'b0;
        bus.skip_m2     = 1'b0;
        bus.uart_done   = 1'b0;
        bus.uart_addr   = '0;
        bus.uart_wdata  = '0;
        bus.uart_we_n   = 1'b1;
        bus.m2_done     = 1'b0;
        bus.m2_addr     = '0;
        bus.m2_wdata    = '0;
        bus.m2_we_n     = 1'b1;
        bus.m1_done     = 1'b0;
        bus.m1_addr     = '0;
        bus.m1_wdata    = '0;
        bus.m1_we_n     = 1'b1;
        bus.vga_addr    = '0;

        $display("[TB] reset");
        applyStimulus(2);
        resetn = 1'b1;
        checkOutput("reset_state", 32'(bus.state_code), 32'd0);
        checkOutput("reset_addr", 32'(bus.SRAM_address), 32'd0);
        checkOutput("reset_wdata", 32'(bus.SRAM_write_data), 32'd0);
        checkOutput("reset_we_n", 32'(bus.SRAM_we_n), 32'd1);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_error", 32'(bus.error), 32'd0);
        checkOutput("reset_starts", {30'd0, bus.m2_start, bus.m1_start}, 32'd0);
        checkOutput("reset_enables", {30'd0, bus.uart_enable, bus.vga_enable}, 32'd0);
        checkOutput("reset_m2_cycles", bus.m2_cycles, 32'd0);
        checkOutput("reset_m1_cycles", bus.m1_cycles, 32'd0);

        $display("[TB] full sequence");
        bus.start = 1'b1;
        applyStimulus(1);
        bus.start = 1'b0;
        checkOutput("uart_state", 32'(bus.state_code), 32'd1);
        checkOutput("uart_enable", 32'(bus.uart_enable), 32'd1);
        checkOutput("uart_busy", 32'(bus.busy), 32'd1);
        bus.uart_addr  = 18'h12345;
        bus.uart_wdata = 16'hBEEF;
        bus.uart_we_n  = 1'b0;
        bus.m2_we_n    = 1'b0;
        bus.m1_we_n    = 1'b0;
        #1;
        checkOutput("uart_mux_addr", 32'(bus.SRAM_address), 32'h12345);
        checkOutput("uart_mux_wdata", 32'(bus.SRAM_write_data), 32'hBEEF);
        checkOutput("uart_mux_we_n", 32'(bus.SRAM_we_n), 32'd0);
        applyStimulus(4);
        bus.uart_done = 1'b1;
        #1;
        checkOutput("uart_done_cycle_addr", 32'(bus.SRAM_address), 32'h12345);
        applyStimulus(1);
        bus.uart_done = 1'b0;
        checkOutput("m2_state", 32'(bus.state_code), 32'd2);
        checkOutput("m2_start_pulse", 32'(bus.m2_start), 32'd1);
        checkOutput("m2_entry_m1_start", 32'(bus.m1_start), 32'd0);
        bus.m2_addr  = 18'h0ABCD;
        bus.m2_wdata = 16'h1234;
        #1;
        checkOutput("m2_mux_addr", 32'(bus.SRAM_address), 32'h0ABCD);
        checkOutput("m2_mux_wdata", 32'(bus.SRAM_write_data), 32'h1234);
        applyStimulus(1);
        checkOutput("m2_start_one_cycle", 32'(bus.m2_start), 32'd0);
        applyStimulus(1);
        bus.start   = 1'b1;
        bus.m1_done = 1'b1;
        applyStimulus(1);
        bus.start   = 1'b0;
        bus.m1_done = 1'b0;
        checkOutput("m2_ignores_start_m1done", 32'(bus.state_code), 32'd2);
        checkOutput("m2_ignores_start_uart_en", 32'(bus.uart_enable), 32'd0);
        applyStimulus(4);
        bus.m2_done = 1'b1;
        applyStimulus(1);
        bus.m2_done = 1'b0;
        checkOutput("m1_state", 32'(bus.state_code), 32'd3);
        checkOutput("m1_start_pulse", 32'(bus.m1_start), 32'd1);
        checkOutput("m2_cycles_full", bus.m2_cycles, 32'd8);
        bus.uart_we_n = 1'b0;
        bus.m2_we_n   = 1'b0;
        bus.m1_we_n   = 1'b1;
        bus.m1_addr   = 18'h23F00;
        #1;
        checkOutput("m1_isolation_we_n", 32'(bus.SRAM_we_n), 32'd1);
        checkOutput("m1_isolation_addr", 32'(bus.SRAM_address), 32'h23F00);
        applyStimulus(4);
        bus.m1_done = 1'b1;
        applyStimulus(1);
        bus.m1_done = 1'b0;
        checkOutput("display_state", 32'(bus.state_code), 32'd4);
        checkOutput("display_busy", 32'(bus.busy), 32'd0);
        checkOutput("display_error", 32'(bus.error), 32'd0);
        checkOutput("display_vga_enable", 32'(bus.vga_enable), 32'd1);
        checkOutput("m1_cycles_full", bus.m1_cycles, 32'd5);
        checkOutput("m2_cycles_held", bus.m2_cycles, 32'd8);
        bus.vga_addr = 18'h2ABCD;
        bus.m1_we_n  = 1'b0;
        #1;
        checkOutput("display_addr", 32'(bus.SRAM_address), 32'h2ABCD);
        checkOutput("display_we_n", 32'(bus.SRAM_we_n), 32'd1);
        checkOutput("display_wdata", 32'(bus.SRAM_write_data), 32'd0);

        $display("[TB] skip M2 and M1 done on terminal count");
        bus.start   = 1'b1;
        bus.skip_m2 = 1'b1;
        applyStimulus(1);
        bus.start   = 1'b0;
        bus.skip_m2 = 1'b0;
        checkOutput("skip_uart_state", 32'(bus.state_code), 32'd1);
        checkOutput("skip_m1_cycles_cleared", bus.m1_cycles, 32'd0);
        checkOutput("skip_m2_cycles_cleared", bus.m2_cycles, 32'd0);
        bus.uart_done = 1'b1;
        applyStimulus(1);
        bus.uart_done = 1'b0;
        checkOutput("skip_to_m1", 32'(bus.state_code), 32'd3);
        checkOutput("skip_no_m2_start", 32'(bus.m2_start), 32'd0);
        checkOutput("skip_m1_start", 32'(bus.m1_start), 32'd1);
        applyStimulus(15);
        checkOutput("terminal_still_m1", 32'(bus.state_code), 32'd3);
        bus.m1_done = 1'b1;
        applyStimulus(1);
        bus.m1_done = 1'b0;
        checkOutput("terminal_done_display", 32'(bus.state_code), 32'd4);
        checkOutput("terminal_done_no_error", 32'(bus.error), 32'd0);
        checkOutput("terminal_m1_cycles", bus.m1_cycles, 32'd16);
        checkOutput("skip_m2_cycles_zero", bus.m2_cycles, 32'd0);

        $display("[TB] M2 timeout");
        bus.start = 1'b1;
        applyStimulus(1);
        bus.start     = 1'b0;
        bus.uart_done = 1'b1;
        applyStimulus(1);
        bus.uart_done = 1'b0;
        bus.m2_we_n   = 1'b0;
        checkOutput("timeout_m2_entry", 32'(bus.state_code), 32'd2);
        applyStimulus(15);
        checkOutput("timeout_before_terminal", 32'(bus.state_code), 32'd2);
        applyStimulus(1);
        checkOutput("timeout_state", 32'(bus.state_code), 32'd5);
        checkOutput("timeout_error", 32'(bus.error), 32'd1);
        checkOutput("timeout_busy", 32'(bus.busy), 32'd0);
        checkOutput("timeout_we_n", 32'(bus.SRAM_we_n), 32'd1);
        checkOutput("timeout_m2_cycles", bus.m2_cycles, 32'd16);
        bus.start = 1'b1;
        applyStimulus(1);
        bus.start = 1'b0;
        checkOutput("restart_error_clear", 32'(bus.error), 32'd0);
        checkOutput("restart_state", 32'(bus.state_code), 32'd1);
        checkOutput("restart_m2_cycles", bus.m2_cycles, 32'd0);

        $display("[TB] reset mid-run");
        bus.uart_done = 1'b1;
        applyStimulus(1);
        bus.uart_done = 1'b0;
        bus.m2_done   = 1'b1;
        applyStimulus(1);
        bus.m2_done   = 1'b0;
        bus.m1_we_n   = 1'b0;
        #1;
        checkOutput("prereset_m1_state", 32'(bus.state_code), 32'd3);
        checkOutput("prereset_m1_we_n", 32'(bus.SRAM_we_n), 32'd0);
        resetn = 1'b0;
        applyStimulus(1);
        resetn = 1'b1;
        checkOutput("midreset_state", 32'(bus.state_code), 32'd0);
        checkOutput("midreset_we_n", 32'(bus.SRAM_we_n), 32'd1);
        checkOutput("midreset_m1_start", 32'(bus.m1_start), 32'd0);
        checkOutput("midreset_m1_cycles", bus.m1_cycles, 32'd0);
        checkOutput("midreset_m2_cycles", bus.m2_cycles, 32'd0);
        bus.uart_done = 1'b1;
        applyStimulus(1);
        bus.uart_done = 1'b0;
        checkOutput("idle_ignores_uart_done", 32'(bus.state_code), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sram_stage_sequencer.md
# sram_stage_sequencer

Top-level sequencer for the image decoder's single SRAM port. It steps the design through UART load, Milestone 2 (IDCT), Milestone 1 (YUV→RGB) and VGA display. Each phase gets exclusive ownership of the SRAM address, write-data and write-enable lines. The sequencer issues start pulses, collects done pulses, times out hung stages and reports per-stage cycle counts.

## Interface
- TIMEOUT_CYCLES, 4000000: maximum cycles allowed in an M2 or M1 run, from the start pulse to done.
- Clock  in  1  system clock; all logic is on the rising edge.
- Resetn  in  1  reset, synchronous and active-low.
- start  in  1  one-cycle pulse that starts a full decode sequence.
- skip_m2  in  1  sampled on an accepted start; 1 bypasses the M2 phase.
- uart_enable  out  1  level, high throughout S_UART.
- uart_done  in  1  pulse, load complete.
- uart_addr / uart_wdata / uart_we_n  in  18/16/1  UART loader SRAM request.
- m2_start / m1_start  out  1  one-cycle start pulse to each milestone; m1_start drives the M1 Enable input.
- m2_done / m1_done  in  1  one-cycle completion pulse from each milestone.
- m2_addr / m2_wdata / m2_we_n, m1_addr / m1_wdata / m1_we_n  in  18/16/1  milestone SRAM requests.
- vga_enable  out  1  level, high throughout S_DISPLAY.
- vga_addr  in  18  VGA read address.
- SRAM_address / SRAM_write_data / SRAM_we_n  out  18/16/1  muxed SRAM port; SRAM_we_n is active-low.
- busy  out  1  high in S_UART, S_M2, S_M1.
- error  out  1  sticky timeout flag.
- state_code  out  3  encoding: 0 IDLE, 1 UART, 2 M2, 3 M1, 4 DISPLAY, 5 ERROR.
- m2_cycles / m1_cycles  out  32  cycle count of the last run of each stage.

## Operation
- States: S_IDLE, S_UART, S_M2, S_M1, S_DISPLAY, S_ERROR. The state register and the grant are the same register.
- S_IDLE, S_DISPLAY, S_ERROR: a start pulse goes to S_UART, latches skip_m2, and clears error, m2_cycles and m1_cycles.
- S_UART: on uart_done, go to S_M1 if skip_m2 was latched, otherwise to S_M2. No timeout applies to S_UART.
- S_M2: on m2_done, go to S_M1.
- S_M1: on m1_done, go to S_DISPLAY.
- S_M2 / S_M1 timeout: a 32-bit watchdog is cleared on entry. If it reaches TIMEOUT_CYCLES-1 without a done pulse, go to S_ERROR and set error=1.
- A done pulse in the same cycle as the watchdog terminal count is a normal completion, not an error.
- start in S_UART, S_M2 or S_M1 is ignored.
- Done pulses from a requester that is not the current owner are ignored.
- Port mux (combinational from state):
  - S_UART → uart_*
  - S_M2 → m2_*
  - S_M1 → m1_*
  - S_DISPLAY → {vga_addr, 16'd0, we_n=1}
  - all other states → {18'd0, 16'd0, we_n=1}
- No non-owner requester can ever cause SRAM_we_n=0.
- Cycle counters: m2_cycles / m1_cycles increment on every cycle spent in S_M2 / S_M1, including the start-pulse cycle and the done cycle. They hold their value afterwards, and hold the partial count after a timeout.

## Timing
- Reset values:
  - state S_IDLE (state_code 0)
  - SRAM_address 0, SRAM_write_data 0, SRAM_we_n 1
  - all start and enable outputs 0
  - busy 0, error 0, both cycle counters 0
- Reset applies regardless of state; a decode interrupted by reset is abandoned and the owner loses the port in the cycle after the reset edge.
- start sampled at edge N: state = S_UART and uart_enable=1 from cycle N+1.
- Done sampled at edge N: the next state owns the port from cycle N+1.
- m2_start / m1_start are registered and high for exactly the first cycle of S_M2 / S_M1.
- The outgoing owner's request is visible on the SRAM port up to and including the cycle its done pulse is high.
- Mux latency is 0: SRAM_* follows the owner's inputs in the same cycle.
- Minimum sequence length: UART done in cycle 1 and each milestone done in the cycle after its start gives S_UART, S_M2, S_M1 of 1, 2 and 2 cycles respectively.

## Test plan
- Full sequence (TIMEOUT_CYCLES=16):
  - start → uart_done after 5 cycles → m2_done 7 cycles after m2_start → m1_done 4 cycles after m1_start.
  - Required: state_code 1→2→3→4, m2_cycles=8, m1_cycles=5, busy falls on entry to DISPLAY, error=0.
- skip_m2=1 at start: uart_done goes directly to state_code 3; m2_start is never asserted; m2_cycles=0.
- Mux isolation:
  - In S_M1, drive uart_we_n=0, m2_we_n=0, m1_we_n=1, m1_addr=18'h23F00.
  - Required: SRAM_we_n=1, SRAM_address=18'h23F00.
  - In S_DISPLAY, SRAM_address=vga_addr and SRAM_we_n=1.
- Timeout (TIMEOUT_CYCLES=16):
  - Withhold m2_done → state_code 5 after 16 cycles in S_M2, error=1, SRAM_we_n=1, m2_cycles=16.
  - Then pulse start → error=0, state_code 1.
- Boundary conditions:
  - m1_done on the watchdog terminal cycle → S_DISPLAY, error=0.
  - start pulsed during S_M2 → ignored.
  - m1_done pulsed during S_M2 → ignored.
- Reset mid-run: Resetn=0 for one cycle during S_M1 → next cycle state_code 0, SRAM_we_n=1, m1_start=0, counters 0.
